// File: rtl/dual_port_ram_resp.sv
// Responder end of a dual-port RAM: one write port and one pipelined read port, with range/collision flags and saturating counters.
// Optional macro RAM_WR_BYPASS_EN: a same-address write/read returns the new write data instead of the old contents.
module dual_port_ram_resp #(
    parameter int DEPTH  = 16,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_enbl,
    input  logic [AWIDTH-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_enbl,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_data,
    output logic              rd_valid,
    output logic              wr_err,
    output logic              rd_err,
    output logic              collision,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt
);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [RD_LAT-1:0] vld_q, vld_d, err_q, err_d;
    logic [DWIDTH-1:0] dat_q [RD_LAT];
    logic [DWIDTH-1:0] dat_d [RD_LAT];
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              wr_err_q, coll_q;
    logic              wr_in_rng, rd_in_rng, wr_ok, rd_ok, coll;
    logic [DWIDTH-1:0] rd_word;

    assign wr_in_rng = 32'(wr_addr) < 32'(DEPTH);
    assign rd_in_rng = 32'(rd_addr) < 32'(DEPTH);
    assign wr_ok     = wr_enbl && wr_in_rng;
    assign rd_ok     = rd_enbl && rd_in_rng;
    assign coll      = wr_ok && rd_ok && (wr_addr == rd_addr);

    // Array is sampled at capture; out-of-range reads carry zero through the pipe.
    always_comb begin
        rd_word = '0;
        if (rd_ok) rd_word = mem_q[rd_addr];
`ifdef RAM_WR_BYPASS_EN
        if (coll) rd_word = wr_data;
`endif
    end

    always_comb begin
        vld_d[0] = rd_enbl;
        err_d[0] = rd_enbl && !rd_in_rng;
        dat_d[0] = rd_enbl ? rd_word : dat_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            err_d[i] = err_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (wr_ok && !(&wr_cnt_q)) wr_cnt_d = wr_cnt_q + CNT_W'(1);
        if (vld_d[RD_LAT-1] && !(&rd_cnt_q)) rd_cnt_d = rd_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q    <= '0;
            err_q    <= '0;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            wr_err_q <= 1'b0;
            coll_q   <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            err_q    <= err_d;
            for (int i = 0; i < RD_LAT; i++) dat_q[i] <= dat_d[i];
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            wr_err_q <= wr_enbl && !wr_in_rng;
            coll_q   <= coll;
        end
    end

    assign rd_data   = dat_q[RD_LAT-1];
    assign rd_valid  = vld_q[RD_LAT-1];
    assign rd_err    = err_q[RD_LAT-1];
    assign wr_err    = wr_err_q;
    assign collision = coll_q;
    assign wr_cnt    = wr_cnt_q;
    assign rd_cnt    = rd_cnt_q;

`ifndef SYNTHESIS
    // Unknown enables would silently act as idle in hardware; flag them in simulation.
    a_wr_enbl_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(wr_enbl));
    a_rd_enbl_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(rd_enbl));
`endif

endmodule

// File: tb/tb_dual_port_ram_resp.sv
// Directed bench: instance A uses default parameters, instance B uses DEPTH=12, RD_LAT=3, CNT_W=4 on the same input bus.
module tb_dual_port_ram_resp;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_enbl = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_enbl = 1'b0;
    logic [3:0] rd_addr = '0;

    logic [7:0]  a_rd_data, b_rd_data;
    logic        a_rd_valid, a_wr_err, a_rd_err, a_collision;
    logic        b_rd_valid, b_wr_err, b_rd_err, b_collision;
    logic [15:0] a_wr_cnt, a_rd_cnt;
    logic [3:0]  b_wr_cnt, b_rd_cnt;

    int nvec = 0;
    int nerr = 0;

`ifdef RAM_WR_BYPASS_EN
    localparam logic [7:0] COLL_EXP = 8'h22;
`else
    localparam logic [7:0] COLL_EXP = 8'h11;
`endif

    always #5 clk = ~clk;

    dual_port_ram_resp dut_a (
        .clk(clk), .rst(rst),
        .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enbl(rd_enbl), .rd_addr(rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid), .wr_err(a_wr_err), .rd_err(a_rd_err),
        .collision(a_collision), .wr_cnt(a_wr_cnt), .rd_cnt(a_rd_cnt)
    );

    dual_port_ram_resp #(.DEPTH(12), .DWIDTH(8), .AWIDTH(4), .RD_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .wr_enbl(wr_enbl), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enbl(rd_enbl), .rd_addr(rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid), .wr_err(b_wr_err), .rd_err(b_rd_err),
        .collision(b_collision), .wr_cnt(b_wr_cnt), .rd_cnt(b_rd_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        wr_enbl = 1'b0;
        rd_enbl = 1'b0;
    endtask

    task automatic do_reset();
        idle_bus();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) begin
            wr_enbl = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'h30 + i);
            tick();
        end
        idle_bus();
        rst = 1'b0;
        #1;
        nvec++; if (a_wr_cnt !== 16'd0) begin nerr++; $display("FAIL async_rst_wr_cnt: got %0d expected 0", a_wr_cnt); end
        for (int i = 0; i < 3; i++) begin
            wr_enbl = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom); wr_data = 8'($urandom);
            rd_enbl = 1'($urandom_range(0, 1)); rd_addr = 4'($urandom);
            tick();
        end
        idle_bus();
        rst = 1'b1;
        #1;
        nvec++; if ({a_rd_data, a_rd_valid, a_wr_err, a_rd_err, a_collision} !== 12'h000) begin
            nerr++; $display("FAIL rst_outputs_a: got %h expected 000", {a_rd_data, a_rd_valid, a_wr_err, a_rd_err, a_collision}); end
        nvec++; if ({a_wr_cnt, a_rd_cnt} !== 32'h0) begin nerr++; $display("FAIL rst_counters_a: got %h expected 0", {a_wr_cnt, a_rd_cnt}); end
        nvec++; if ({b_rd_data, b_rd_valid, b_wr_cnt, b_rd_cnt} !== 17'h0) begin
            nerr++; $display("FAIL rst_outputs_b: got %h expected 0", {b_rd_data, b_rd_valid, b_wr_cnt, b_rd_cnt}); end
        for (int i = 0; i < 16; i++) begin
            rd_enbl = 1'b1; rd_addr = 4'(i);
            tick();
            nvec++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
                nerr++; $display("FAIL rst_clear_addr%0d: got valid=%b data=%h expected valid=1 data=00", i, a_rd_valid, a_rd_data); end
        end
        idle_bus();
        tick();
        nvec++; if (a_rd_cnt !== 16'd16) begin nerr++; $display("FAIL rst_read_count: got %0d expected 16", a_rd_cnt); end
        tick(); tick();
    endtask

    task automatic test_write_read();
        do_reset();
        wr_enbl = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
        tick();
        wr_enbl = 1'b0;
        nvec++; if (a_rd_valid !== 1'b0) begin nerr++; $display("FAIL wr_no_valid: got %b expected 0", a_rd_valid); end
        rd_enbl = 1'b1; rd_addr = 4'd3;
        tick();
        rd_enbl = 1'b0;
        nvec++; if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hA5) begin
            nerr++; $display("FAIL wr_rd_data: got valid=%b data=%h expected valid=1 data=a5", a_rd_valid, a_rd_data); end
        nvec++; if (a_wr_cnt !== 16'd1 || a_rd_cnt !== 16'd1) begin
            nerr++; $display("FAIL wr_rd_counts: got wr=%0d rd=%0d expected 1 1", a_wr_cnt, a_rd_cnt); end
        tick();
        nvec++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'hA5 || a_rd_cnt !== 16'd1) begin
            nerr++; $display("FAIL rd_hold: got valid=%b data=%h rd=%0d expected 0 a5 1", a_rd_valid, a_rd_data, a_rd_cnt); end
    endtask

    task automatic test_collision();
        do_reset();
        wr_enbl = 1'b1; wr_addr = 4'd7; wr_data = 8'h11;
        tick();
        rd_enbl = 1'b1; rd_addr = 4'd7; wr_data = 8'h22;
        tick();
        idle_bus();
        nvec++; if (a_rd_valid !== 1'b1 || a_rd_data !== COLL_EXP) begin
            nerr++; $display("FAIL coll_data: got valid=%b data=%h expected valid=1 data=%h", a_rd_valid, a_rd_data, COLL_EXP); end
        nvec++; if (a_collision !== 1'b1 || b_collision !== 1'b1) begin
            nerr++; $display("FAIL coll_flag: got a=%b b=%b expected 1 1", a_collision, b_collision); end
        wr_enbl = 1'b1; wr_addr = 4'd8; wr_data = 8'h33;
        rd_enbl = 1'b1; rd_addr = 4'd7;
        tick();
        nvec++; if (a_collision !== 1'b0) begin nerr++; $display("FAIL coll_pulse: got %b expected 0", a_collision); end
        nvec++; if (a_rd_data !== 8'h22) begin nerr++; $display("FAIL coll_later_read: got %h expected 22", a_rd_data); end
        wr_enbl = 1'b0; rd_addr = 4'd8;
        tick();
        rd_enbl = 1'b0;
        nvec++; if (a_collision !== 1'b0 || a_rd_data !== 8'h33) begin
            nerr++; $display("FAIL diff_addr: got coll=%b data=%h expected 0 33", a_collision, a_rd_data); end
        tick(); tick();
    endtask

    task automatic test_out_of_range();
        do_reset();
        wr_enbl = 1'b1; wr_addr = 4'd5; wr_data = 8'h77;
        rd_enbl = 1'b0;
        tick();
        wr_enbl = 1'b0; rd_enbl = 1'b1; rd_addr = 4'd5;
        tick();
        rd_enbl = 1'b0;
        tick(); tick();
        nvec++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h77 || b_rd_err !== 1'b0) begin
            nerr++; $display("FAIL oor_pre_read: got valid=%b data=%h err=%b expected 1 77 0", b_rd_valid, b_rd_data, b_rd_err); end
        wr_enbl = 1'b1; wr_addr = 4'd13; wr_data = 8'h5A;
        tick();
        wr_enbl = 1'b0;
        nvec++; if (b_wr_err !== 1'b1 || b_wr_cnt !== 4'd1) begin
            nerr++; $display("FAIL oor_write_b: got err=%b cnt=%0d expected 1 1", b_wr_err, b_wr_cnt); end
        nvec++; if (a_wr_err !== 1'b0 || a_wr_cnt !== 16'd2) begin
            nerr++; $display("FAIL oor_write_a: got err=%b cnt=%0d expected 0 2", a_wr_err, a_wr_cnt); end
        rd_enbl = 1'b1; rd_addr = 4'd14;
        tick();
        rd_enbl = 1'b0;
        nvec++; if (b_wr_err !== 1'b0) begin nerr++; $display("FAIL oor_wr_err_pulse: got %b expected 0", b_wr_err); end
        tick();
        nvec++; if (b_rd_valid !== 1'b0) begin nerr++; $display("FAIL oor_early_valid: got %b expected 0", b_rd_valid); end
        tick();
        nvec++; if (b_rd_valid !== 1'b1 || b_rd_err !== 1'b1 || b_rd_data !== 8'h00 || b_rd_cnt !== 4'd2) begin
            nerr++; $display("FAIL oor_read: got valid=%b err=%b data=%h cnt=%0d expected 1 1 00 2", b_rd_valid, b_rd_err, b_rd_data, b_rd_cnt); end
        wr_enbl = 1'b1; wr_addr = 4'd13; wr_data = 8'h01;
        rd_enbl = 1'b1; rd_addr = 4'd13;
        tick();
        idle_bus();
        nvec++; if (b_rd_err !== 1'b0 || b_rd_valid !== 1'b0) begin
            nerr++; $display("FAIL oor_rd_err_pulse: got err=%b valid=%b expected 0 0", b_rd_err, b_rd_valid); end
        nvec++; if (b_collision !== 1'b0 || a_collision !== 1'b1) begin
            nerr++; $display("FAIL oor_collision: got b=%b a=%b expected 0 1", b_collision, a_collision); end
        tick(); tick();
    endtask

    task automatic test_pipeline();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr_enbl = 1'b1; wr_addr = 4'(i); wr_data = 8'(8'hC0 + i);
            tick();
        end
        wr_enbl = 1'b0;
        for (int t = 0; t < 4; t++) begin
            rd_enbl = 1'b1; rd_addr = 4'(t);
            tick();
            if (t < 2) begin
                nvec++; if (b_rd_valid !== 1'b0) begin nerr++; $display("FAIL pipe_t%0d_valid: got %b expected 0", t, b_rd_valid); end
            end else begin
                nvec++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'(8'hC0 + t - 2)) begin
                    nerr++; $display("FAIL pipe_t%0d_data: got valid=%b data=%h expected 1 %h", t, b_rd_valid, b_rd_data, 8'(8'hC0 + t - 2)); end
            end
        end
        nvec++; if (b_rd_cnt !== 4'd2) begin nerr++; $display("FAIL pipe_rd_cnt: got %0d expected 2", b_rd_cnt); end
        idle_bus();
        rst = 1'b0;
        #1;
        nvec++; if (b_rd_valid !== 1'b0) begin nerr++; $display("FAIL pipe_async_flush: got %b expected 0", b_rd_valid); end
        tick();
        rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            nvec++; if (b_rd_valid !== 1'b0) begin nerr++; $display("FAIL pipe_dropped_%0d: got %b expected 0", t, b_rd_valid); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            wr_enbl = 1'b1; wr_addr = 4'(i % 12); wr_data = 8'(i);
            tick();
            nvec++; if (b_wr_cnt !== 4'((i + 1 > 15) ? 15 : i + 1)) begin
                nerr++; $display("FAIL sat_wr_%0d: got %0d expected %0d", i, b_wr_cnt, (i + 1 > 15) ? 15 : i + 1); end
        end
        wr_enbl = 1'b0;
        tick();
        nvec++; if (b_wr_cnt !== 4'd15 || a_wr_cnt !== 16'd20) begin
            nerr++; $display("FAIL sat_hold: got b=%0d a=%0d expected 15 20", b_wr_cnt, a_wr_cnt); end
    endtask

    initial begin
        idle_bus();
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_write_read();
        test_collision();
        test_out_of_range();
        test_pipeline();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
